// File: rtl/raster_timing.sv
// Raster timing generator: sync, active-area flags, pixel/line positions and the
// framebuffer row address with vertical scroll, line repeat and a border window.
module raster_timing #(
   parameter int H_FP     = 11,
   parameter int H_SYNC   = 56,
   parameter int H_BP     = 61,
   parameter int H_ACT    = 640,
   parameter int V_FP     = 17,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 15,
   parameter int V_ACT    = 588,
   parameter int FB_TOP   = 42,
   parameter int FB_LINES = 512,
   parameter int REPEAT   = 1,
   parameter int ROW_LSB  = 1,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic                 clk24,
   input  logic                 reset,
   input  logic                 ce,
   input  logic [7:0]           scroll,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 active_x,
   output logic                 active_y,
   output logic                 video_active,
   output logic                 retrace,
   output logic                 border_y,
   output logic [9:0]           xpos,
   output logic [9:0]           ypos,
   output logic [8+ROW_LSB-1:0] fb_row,
   output logic                 line_start,
   output logic                 frame_start
);

   localparam int H_TOT = H_FP + H_SYNC + H_BP + H_ACT;
   localparam int V_TOT = V_FP + V_SYNC + V_BP + V_ACT;
   localparam int H_AST = H_TOT - H_ACT;
   localparam int V_AST = V_TOT - V_ACT;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int RW    = 8 + ROW_LSB;
   localparam int WCW   = $clog2(FB_LINES + 1);
   localparam int RPW   = $clog2(REPEAT + 1);

   logic [HW-1:0]  hcnt_q, hcnt_d;
   logic [VW-1:0]  vcnt_q, vcnt_d;
   logic           h_wrap, v_wrap;
   logic           hsync_q, hsync_d, vsync_q, vsync_d;
   logic           ax_q, ax_d, ay_q, ay_d, va_q, rt_q;
   logic           border_q, border_d;
   logic [9:0]     xpos_q, xpos_d, ypos_q, ypos_d;
   logic [RW-1:0]  fb_row_q, fb_row_d;
   logic [WCW-1:0] win_q, win_d;
   logic [RPW-1:0] rep_q, rep_d;
   logic           ls_q, fs_q;

   // Outputs are decoded from the next counter values so they land with the counter.
   always_comb begin
      h_wrap = (hcnt_q == HW'(H_TOT - 1));
      v_wrap = h_wrap && (vcnt_q == VW'(V_TOT - 1));
      hcnt_d = h_wrap ? '0 : hcnt_q + HW'(1);
      vcnt_d = vcnt_q;
      if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + VW'(1);

      hsync_d = (int'(hcnt_d) >= H_FP && int'(hcnt_d) < H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d = (int'(vcnt_d) >= V_FP && int'(vcnt_d) < V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
      ax_d    = (int'(hcnt_d) >= H_AST);
      ay_d    = (int'(vcnt_d) >= V_AST);
      xpos_d  = ax_d ? 10'(hcnt_d - HW'(H_AST)) : '0;
      ypos_d  = ay_d ? 10'(vcnt_d - VW'(V_AST)) : '0;

      fb_row_d = fb_row_q;
      border_d = border_q;
      win_d    = win_q;
      rep_d    = rep_q;
      if (h_wrap) begin
         if (!ay_d) begin
            border_d = 1'b1;
         end else if (int'(ypos_d) == FB_TOP) begin
            fb_row_d = (RW'(scroll) << ROW_LSB) | RW'((1 << ROW_LSB) - 1);
            rep_d    = '0;
            win_d    = WCW'(FB_LINES - 1);
            border_d = 1'b0;
         end else if (!border_q) begin
            if (win_q == '0) begin
               border_d = 1'b1;
            end else begin
               win_d = win_q - WCW'(1);
               if (rep_q == RPW'(REPEAT - 1)) begin
                  rep_d    = '0;
                  fb_row_d = fb_row_q - RW'(1);
               end else begin
                  rep_d = rep_q + RPW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk24) begin
      if (reset) begin
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         hsync_q  <= ~SYNC_POL;
         vsync_q  <= ~SYNC_POL;
         ax_q     <= 1'b0;
         ay_q     <= 1'b0;
         va_q     <= 1'b0;
         rt_q     <= 1'b1;
         border_q <= 1'b1;
         xpos_q   <= '0;
         ypos_q   <= '0;
         fb_row_q <= '0;
         win_q    <= '0;
         rep_q    <= '0;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         // Pulses last one clk24 cycle even when ce stays high or drops.
         ls_q <= ce & h_wrap;
         fs_q <= ce & v_wrap;
         if (ce) begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            va_q     <= ax_d & ay_d;
            rt_q     <= ~ay_d;
            border_q <= border_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            fb_row_q <= fb_row_d;
            win_q    <= win_d;
            rep_q    <= rep_d;
         end
      end
   end

   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign active_x     = ax_q;
   assign active_y     = ay_q;
   assign video_active = va_q;
   assign retrace      = rt_q;
   assign border_y     = border_q;
   assign xpos         = xpos_q;
   assign ypos         = ypos_q;
   assign fb_row       = fb_row_q;
   assign line_start   = ls_q;
   assign frame_start  = fs_q;

endmodule

// File: tb/tb_raster_timing.sv
// Bench for raster_timing: two small-timing instances (line repeat 1 / 2, both sync
// polarities) checked every cycle against a frame-level reference model.
module tb_raster_timing;

   localparam int H_FP = 2, H_SYNC = 3, H_BP = 2, H_ACT = 8;
   localparam int V_FP = 1, V_SYNC = 1, V_BP = 1, V_ACT = 6;
   localparam int H_TOT = H_FP + H_SYNC + H_BP + H_ACT;
   localparam int V_TOT = V_FP + V_SYNC + V_BP + V_ACT;
   localparam int H_AST = H_TOT - H_ACT;
   localparam int V_AST = V_TOT - V_ACT;

   int P_FBTOP [2] = '{1, 1};
   int P_FBL   [2] = '{3, 10};
   int P_REP   [2] = '{1, 2};
   int P_POL   [2] = '{0, 1};

   logic       clk24 = 1'b0;
   logic       reset = 1'b1;
   logic       ce = 1'b0;
   logic [7:0] scroll = 8'h00;

   logic       hs [2], vs [2], ax [2], ay [2], va [2], rt [2], by [2], ls [2], fs [2];
   logic [9:0] xp [2], yp [2];
   logic [8:0] fb [2];

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   int hc, vc;
   bit m_ls, m_fs;
   bit cur_valid [2];
   int cur_start [2];
   int prev_final [2];

   always #5 clk24 = ~clk24;

   raster_timing #(
      .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT),
      .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT),
      .FB_TOP(1), .FB_LINES(3), .REPEAT(1), .ROW_LSB(1), .SYNC_POL(1'b0)
   ) dut_a (
      .clk24(clk24), .reset(reset), .ce(ce), .scroll(scroll),
      .hsync(hs[0]), .vsync(vs[0]), .active_x(ax[0]), .active_y(ay[0]),
      .video_active(va[0]), .retrace(rt[0]), .border_y(by[0]),
      .xpos(xp[0]), .ypos(yp[0]), .fb_row(fb[0]),
      .line_start(ls[0]), .frame_start(fs[0])
   );

   raster_timing #(
      .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT),
      .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT),
      .FB_TOP(1), .FB_LINES(10), .REPEAT(2), .ROW_LSB(1), .SYNC_POL(1'b1)
   ) dut_b (
      .clk24(clk24), .reset(reset), .ce(ce), .scroll(scroll),
      .hsync(hs[1]), .vsync(vs[1]), .active_x(ax[1]), .active_y(ay[1]),
      .video_active(va[1]), .retrace(rt[1]), .border_y(by[1]),
      .xpos(xp[1]), .ypos(yp[1]), .fb_row(fb[1]),
      .line_start(ls[1]), .frame_start(fs[1])
   );

   function automatic int last_k(int i);
      int k = P_FBL[i] - 1;
      if (V_ACT - 1 - P_FBTOP[i] < k) k = V_ACT - 1 - P_FBTOP[i];
      return k;
   endfunction

   // fb_row: start value minus one per REPEAT lines since the window top, frozen
   // at the last window line; before the window it shows the previous frame's end.
   function automatic int exp_fb(int i);
      int y, k;
      y = vc - V_AST;
      if (vc >= V_AST && cur_valid[i] && y >= P_FBTOP[i]) begin
         k = y - P_FBTOP[i];
         if (k > P_FBL[i] - 1) k = P_FBL[i] - 1;
         return (cur_start[i] - k / P_REP[i]) & 511;
      end
      return prev_final[i];
   endfunction

   function automatic int exp_border(int i);
      int y;
      y = vc - V_AST;
      if (vc >= V_AST && cur_valid[i] && y >= P_FBTOP[i] && y - P_FBTOP[i] < P_FBL[i])
         return 0;
      return 1;
   endfunction

   task automatic model_step(input logic ce_v, input logic rst_v, input logic [7:0] sc_v);
      if (rst_v) begin
         hc = 0; vc = 0; m_ls = 0; m_fs = 0;
         for (int i = 0; i < 2; i++) begin
            cur_valid[i] = 0; prev_final[i] = 0; cur_start[i] = 0;
         end
      end else begin
         m_ls = 0; m_fs = 0;
         if (ce_v) begin
            hc++;
            if (hc == H_TOT) begin
               hc = 0; m_ls = 1; vc++;
               if (vc == V_TOT) begin
                  vc = 0; m_fs = 1;
                  for (int i = 0; i < 2; i++) begin
                     if (cur_valid[i]) prev_final[i] = (cur_start[i] - last_k(i) / P_REP[i]) & 511;
                     cur_valid[i] = 0;
                  end
               end
               for (int i = 0; i < 2; i++)
                  if (vc == V_AST + P_FBTOP[i]) begin
                     cur_start[i] = int'(sc_v) * 2 + 1;
                     cur_valid[i] = 1;
                  end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s[%0d] at hc=%0d vc=%0d: observed=%0h expected=%0h", tag, i, hc, vc, obs, expv);
      end
   endtask

   task automatic check_all();
      int ins, x, y;
      bit exs, eys, eax, eay;
      for (int i = 0; i < 2; i++) begin
         exs = (hc >= H_FP && hc < H_FP + H_SYNC);
         eys = (vc >= V_FP && vc < V_FP + V_SYNC);
         eax = (hc >= H_AST);
         eay = (vc >= V_AST);
         x = eax ? hc - H_AST : 0;
         y = eay ? vc - V_AST : 0;
         ins = exs ? P_POL[i] : 1 - P_POL[i];
         chk("hsync", i, 32'(hs[i]), 32'(ins));
         ins = eys ? P_POL[i] : 1 - P_POL[i];
         chk("vsync", i, 32'(vs[i]), 32'(ins));
         chk("active_x", i, 32'(ax[i]), 32'(eax));
         chk("active_y", i, 32'(ay[i]), 32'(eay));
         chk("video_active", i, 32'(va[i]), 32'(eax & eay));
         chk("retrace", i, 32'(rt[i]), 32'(!eay));
         chk("xpos", i, 32'(xp[i]), 32'(x));
         chk("ypos", i, 32'(yp[i]), 32'(y));
         chk("fb_row", i, 32'(fb[i]), 32'(exp_fb(i)));
         chk("border_y", i, 32'(by[i]), 32'(exp_border(i)));
         chk("line_start", i, 32'(ls[i]), 32'(m_ls));
         chk("frame_start", i, 32'(fs[i]), 32'(m_fs));
      end
   endtask

   task automatic step(input logic ce_v, input logic rst_v, input logic [7:0] sc_v);
      @(negedge clk24);
      ce = ce_v; reset = rst_v; scroll = sc_v;
      @(posedge clk24);
      model_step(ce_v, rst_v, sc_v);
      #1;
      check_all();
   endtask

   initial begin
      logic [7:0] sc;
      sc = 8'($urandom);

      // reset, with ce held high to show reset dominates
      for (int n = 0; n < 3; n++) step(1'b1, 1'b1, sc);
      chk("rst_border", 0, 32'(by[0]), 32'd1);
      chk("rst_hsync_pol1", 1, 32'(hs[1]), 32'd0);
      chk("rst_fb_row", 1, 32'(fb[1]), 32'd0);

      // free-running frames, random scroll
      for (int n = 0; n < 3 * H_TOT * V_TOT; n++) step(1'b1, 1'b0, sc);

      // scroll 0x05 then 0x00 for the window/repeat/wrap sequences
      for (int n = 0; n < 2 * H_TOT * V_TOT; n++) step(1'b1, 1'b0, 8'h05);
      for (int n = 0; n < 2 * H_TOT * V_TOT; n++) step(1'b1, 1'b0, 8'h00);
      chk("fb_row_wrap", 1, 32'(fb[1]), 32'h1FF);

      // ce one-in-two
      for (int n = 0; n < 4 * H_TOT * V_TOT; n++) step(1'(n % 2 == 0), 1'b0, 8'h00);

      // random ce and scroll changes at arbitrary points, including mid-window
      sc = 8'($urandom);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 19) == 0) sc = 8'($urandom);
         step(1'($urandom_range(0, 3) != 0), 1'b0, sc);
      end

      // run to hcnt=9, vcnt=4, then a reset pulse together with ce
      for (int n = 0; n < 2 * H_TOT * V_TOT && !(hc == 9 && vc == 4); n++) step(1'b1, 1'b0, sc);
      chk("pre_reset_xpos", 0, 32'(xp[0]), 32'(9 - H_AST));
      chk("pre_reset_ypos", 0, 32'(yp[0]), 32'(4 - V_AST));
      step(1'b1, 1'b1, sc);
      chk("post_reset_xpos", 0, 32'(xp[0]), 32'd0);
      chk("post_reset_vsync_pol1", 1, 32'(vs[1]), 32'd0);

      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 15) == 0) sc = 8'($urandom);
         step(1'($urandom_range(0, 4) != 0), 1'b0, sc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
